sseg_digit_scanner: RTL and testbench

Time-multiplexing front end for the 8-digit seven-segment display. Holds a 32-bit hexadecimal display value, steps through the eight digit positions at a programmable refresh rate, and presents one position's digit index, 4-bit nibble, decimal point and blank flag per scan slot. It sits directly upstream of the seven-segment driver, which consumes `active_digit`/`num`/`dp` and generates `sseg`/`AN`/`DP`. New values are double-buffered and committed only at a frame boundary, so a frame never mixes old and new digits.

---
 rtl/sseg_digit_scanner.sv | 105 ++++++++++
 tb/tb_sseg_digit_scanner.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_digit_scanner.sv
// Eight-digit seven-segment scan front end with a double-buffered display value.
// Optional leading-zero blanking when SSEG_LEADING_ZERO_BLANK_EN is defined.
module sseg_digit_scanner #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic [7:0]  dp_in,
    input  logic        value_valid,
    output logic [2:0]  active_digit,
    output logic [3:0]  num,
    output logic        dp,
    output logic        blank,
    output logic        frame_done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    digit_q, digit_d;
    logic [31:0]   stage_val_q, stage_val_d;
    logic [7:0]    stage_dp_q, stage_dp_d;
    logic          pending_q, pending_d;
    logic [31:0]   disp_val_q, disp_val_d;
    logic [7:0]    disp_dp_q, disp_dp_d;
    logic          frame_done_q, frame_done_d;
    logic          tick, commit;

    assign tick   = (pre_q == PRE_MAX);
    assign commit = tick && (digit_q == 3'd7);

    always_comb begin
        pre_d        = tick ? '0 : pre_q + PW'(1);
        digit_d      = tick ? digit_q + 3'd1 : digit_q;
        stage_val_d  = stage_val_q;
        stage_dp_d   = stage_dp_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        frame_done_d = commit;
        if (value_valid) begin
            stage_val_d = value_in;
            stage_dp_d  = dp_in;
            pending_d   = 1'b1;
        end
        // A strobe landing on the commit tick goes straight to the display.
        if (commit) begin
            if (value_valid) begin
                disp_val_d = value_in;
                disp_dp_d  = dp_in;
            end else if (pending_q) begin
                disp_val_d = stage_val_q;
                disp_dp_d  = stage_dp_q;
            end
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q        <= '0;
            digit_q      <= '0;
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            pending_q    <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            digit_q      <= digit_d;
            stage_val_q  <= stage_val_d;
            stage_dp_q   <= stage_dp_d;
            pending_q    <= pending_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign active_digit = digit_q;
    assign num          = disp_val_q[{digit_q, 2'b00} +: 4];
    assign dp           = disp_dp_q[digit_q];
    assign frame_done   = frame_done_q;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic [7:0] blank_v;
    logic       upper_zero;

    // Walk down from the top nibble; a digit blanks while everything at and above it is zero.
    always_comb begin
        blank_v    = '0;
        upper_zero = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            upper_zero = upper_zero & (disp_val_q[4*i +: 4] == 4'h0);
            blank_v[i] = upper_zero;
        end
    end

    assign blank = blank_v[digit_q];
`else
    assign blank = 1'b0;
`endif
endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Directed bench for sseg_digit_scanner at TICK_DIV=4 (one frame = 32 cycles).
module tb_sseg_digit_scanner;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value_in;
    logic [7:0]  dp_in;
    logic        value_valid;
    logic [2:0]  active_digit;
    logic [3:0]  num;
    logic        dp;
    logic        blank;
    logic        frame_done;

    sseg_digit_scanner #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in),
        .value_valid(value_valid), .active_digit(active_digit), .num(num),
        .dp(dp), .blank(blank), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n;
    int          checks;
    int          fails;
    logic [31:0] exp_val, m_sv;
    logic [7:0]  exp_dp, m_sd;
    logic        m_pend;
    logic [9:0]  obs, expv;

    function automatic logic exp_blank(logic [31:0] v, int d);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        return (d != 0) && ((v >> (4*d)) == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [9:0] exp_vec();
        int d;
        logic [2:0] d3;
        d  = (n / TD) % 8;
        d3 = 3'(d);
        return {d3, exp_val[4*d +: 4], exp_dp[d], exp_blank(exp_val, d), (n > 0) && (n % 32 == 0)};
    endfunction

    // Advance one cycle; the model commits staged data on the frame boundary.
    task automatic step();
        @(negedge clk);
        n++;
        obs = {active_digit, num, dp, blank, frame_done};
        if (n % 32 == 0 && m_pend) begin
            exp_val = m_sv;
            exp_dp  = m_sd;
            m_pend  = 1'b0;
        end
        expv = exp_vec();
    endtask

    task automatic strobe(input logic [31:0] v, input logic [7:0] d);
        value_in    = v;
        dp_in       = d;
        value_valid = 1'b1;
        m_sv = v; m_sd = d; m_pend = 1'b1;
        step();
        value_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; value_valid = 1'b0; value_in = '0; dp_in = '0;
        exp_val = '0; exp_dp = '0; m_sv = '0; m_sd = '0; m_pend = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({active_digit, num, dp, blank, frame_done} !== 10'd0) begin
            fails++;
            $display("FAIL reset_state: got %b expected %b", {active_digit, num, dp, blank, frame_done}, 10'd0);
        end
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_idle_scan();
        int pulses = 0;
        repeat (36) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL idle_scan n=%0d: got %b expected %b", n, obs, expv);
            end
            if (frame_done) pulses++;
        end
        checks++;
        if (active_digit !== 3'd1) begin
            fails++;
            $display("FAIL idle_digit: got %0d expected 1", active_digit);
        end
        checks++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL idle_frame_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_update();
        strobe(32'h1234_5678, 8'h04);
        while (n < 96) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL update n=%0d: got %b expected %b", n, obs, expv);
            end
            if (n == 63) begin
                checks++;
                if (num !== 4'h0) begin
                    fails++;
                    $display("FAIL update_precommit: got %h expected 0", num);
                end
            end
            if (n == 64) begin
                checks++;
                if ({num, dp, frame_done} !== {4'h8, 1'b0, 1'b1}) begin
                    fails++;
                    $display("FAIL update_digit0: got %h/%b/%b expected 8/0/1", num, dp, frame_done);
                end
            end
            if (n == 72) begin
                checks++;
                if ({active_digit, num, dp} !== {3'd2, 4'h6, 1'b1}) begin
                    fails++;
                    $display("FAIL update_digit2: got %0d/%h/%b expected 2/6/1", active_digit, num, dp);
                end
            end
        end
    endtask

    task automatic test_two_strobes();
        strobe(32'hAAAA_AAAA, 8'hFF);
        repeat (5) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL two_strobes n=%0d: got %b expected %b", n, obs, expv);
            end
        end
        strobe(32'h0000_00BC, 8'h00);
        while (n < 160) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL two_strobes n=%0d: got %b expected %b", n, obs, expv);
            end
            if (n == 128 || n == 132 || n == 136) begin
                checks++;
                if (num !== ((n == 128) ? 4'hC : (n == 132) ? 4'hB : 4'h0)) begin
                    fails++;
                    $display("FAIL two_strobes_digit n=%0d: got %h", n, num);
                end
            end
        end
    endtask

    task automatic test_bypass();
        while (n % 32 != 31) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL bypass_pre n=%0d: got %b expected %b", n, obs, expv);
            end
        end
        strobe(32'hDEAD_BEEF, 8'h00);
        checks++;
        if ({active_digit, num, frame_done} !== {3'd0, 4'hF, 1'b1}) begin
            fails++;
            $display("FAIL bypass_commit: got %0d/%h/%b expected 0/f/1", active_digit, num, frame_done);
        end
        repeat (64) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL bypass n=%0d: got %b expected %b", n, obs, expv);
            end
            if (n == 224) begin
                checks++;
                if ({num, frame_done} !== {4'hF, 1'b1}) begin
                    fails++;
                    $display("FAIL bypass_no_recommit: got %h/%b expected f/1", num, frame_done);
                end
            end
            if (n == 212) begin
                checks++;
                if ({active_digit, num} !== {3'd5, 4'hA}) begin
                    fails++;
                    $display("FAIL bypass_digit5: got %0d/%h expected 5/a", active_digit, num);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        strobe(32'h5555_5555, 8'hFF);
        while ((n / TD) % 8 != 5) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL mid_reset_pre n=%0d: got %b expected %b", n, obs, expv);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({active_digit, num, dp, blank, frame_done} !== 10'd0) begin
            fails++;
            $display("FAIL mid_reset_async: got %b expected %b", {active_digit, num, dp, blank, frame_done}, 10'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0; exp_val = '0; exp_dp = '0; m_pend = 1'b0;
        repeat (40) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL mid_reset_after n=%0d: got %b expected %b", n, obs, expv);
            end
            if (n == 32) begin
                checks++;
                if ({num, dp} !== 5'd0) begin
                    fails++;
                    $display("FAIL mid_reset_discard: got %h/%b expected 0/0", num, dp);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic bexp;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        bexp = 1'b1;
`else
        bexp = 1'b0;
`endif
        strobe(32'h0000_0305, 8'h00);
        while (n < 96) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL blank_305 n=%0d: got %b expected %b", n, obs, expv);
            end
            if (n == 72 || n == 76) begin
                checks++;
                if (blank !== ((n == 76) ? bexp : 1'b0)) begin
                    fails++;
                    $display("FAIL blank_305_digit n=%0d: got %b", n, blank);
                end
            end
        end
        strobe(32'h0, 8'h00);
        while (n < 160) begin
            step();
            checks++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL blank_zero n=%0d: got %b expected %b", n, obs, expv);
            end
            if (n == 128 || n == 132) begin
                checks++;
                if (blank !== ((n == 132) ? bexp : 1'b0)) begin
                    fails++;
                    $display("FAIL blank_zero_digit n=%0d: got %b", n, blank);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_idle_scan();
        test_update();
        test_two_strobes();
        test_bypass();
        test_mid_reset();
        test_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
